// File: rtl/dmem_arbiter_if.sv
// Bundle for the two dmem requesters and the dmem port of dmem_arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned WORD_WIDTH = 32
);
   logic                  m0_req,    m1_req;
   logic                  m0_wr_en,  m1_wr_en;
   logic                  m0_lock,   m1_lock;
   logic [ADDR_WIDTH-1:0] m0_addr,   m1_addr;
   logic [WORD_WIDTH-1:0] m0_wdata,  m1_wdata;
   logic                  m0_gnt,    m1_gnt;
   logic                  m0_rvalid, m1_rvalid;
   logic [WORD_WIDTH-1:0] m0_rdata,  m1_rdata;
   logic [ADDR_WIDTH-1:0] dmem_addr;
   logic [WORD_WIDTH-1:0] dmem_data_in;
   logic                  dmem_wr_en;
   logic                  dmem_mem_read;
   logic [WORD_WIDTH-1:0] dmem_data_out;

   modport slave (
      input  m0_req, m1_req, m0_wr_en, m1_wr_en, m0_lock, m1_lock,
      input  m0_addr, m1_addr, m0_wdata, m1_wdata, dmem_data_out,
      output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
      output dmem_addr, dmem_data_in, dmem_wr_en, dmem_mem_read
   );

   modport master (
      output m0_req, m1_req, m0_wr_en, m1_wr_en, m0_lock, m1_lock,
      output m0_addr, m1_addr, m0_wdata, m1_wdata, dmem_data_out,
      input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
      input  dmem_addr, dmem_data_in, dmem_wr_en, dmem_mem_read
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port dmem with locked sequences.
// DMEM_ARB_RR_EN selects round-robin contention; otherwise m0 has fixed priority.
module dmem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned WORD_WIDTH = 32
) (
   input logic            clk,
   input logic            nrst,
   dmem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {FREE, LOCK0, LOCK1} owner_e;

   owner_e                owner_q, owner_d;
   logic                  gnt0, gnt1;
   logic                  rd0, rd1;
   logic                  rvalid0_q, rvalid1_q;
   logic [WORD_WIDTH-1:0] rdata0_q, rdata1_q;
   logic [ADDR_WIDTH-1:0] addr_mux;
   logic [WORD_WIDTH-1:0] wdata_mux;
   logic                  wr_mux, rd_mux;
`ifdef DMEM_ARB_RR_EN
   logic                  last_q, last_d;
`endif

   // Grant is held low during reset so nothing reaches dmem while nrst is low.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (nrst) begin
         case (owner_q)
            FREE: begin
               if (bus.m0_req && bus.m1_req) begin
`ifdef DMEM_ARB_RR_EN
                  gnt0 = last_q;
                  gnt1 = ~last_q;
`else
                  gnt0 = 1'b1;
`endif
               end else begin
                  gnt0 = bus.m0_req;
                  gnt1 = bus.m1_req;
               end
            end
            LOCK0:   gnt0 = bus.m0_req;
            LOCK1:   gnt1 = bus.m1_req;
            default: ;
         endcase
      end
   end

   always_comb begin
      owner_d = FREE;
      if (gnt0 && bus.m0_lock) begin
         owner_d = LOCK0;
      end else if (gnt1 && bus.m1_lock) begin
         owner_d = LOCK1;
      end
   end

`ifdef DMEM_ARB_RR_EN
   always_comb begin
      last_d = last_q;
      if (gnt0) begin
         last_d = 1'b0;
      end else if (gnt1) begin
         last_d = 1'b1;
      end
   end
`endif

   always_comb begin
      addr_mux  = '0;
      wdata_mux = '0;
      wr_mux    = 1'b0;
      rd_mux    = 1'b0;
      if (gnt0) begin
         addr_mux  = bus.m0_addr;
         wdata_mux = bus.m0_wdata;
         wr_mux    = bus.m0_wr_en;
         rd_mux    = ~bus.m0_wr_en;
      end else if (gnt1) begin
         addr_mux  = bus.m1_addr;
         wdata_mux = bus.m1_wdata;
         wr_mux    = bus.m1_wr_en;
         rd_mux    = ~bus.m1_wr_en;
      end
   end

   assign rd0 = gnt0 & ~bus.m0_wr_en;
   assign rd1 = gnt1 & ~bus.m1_wr_en;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         owner_q   <= FREE;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         owner_q   <= owner_d;
         rvalid0_q <= rd0;
         rvalid1_q <= rd1;
         if (rd0) begin
            rdata0_q <= bus.dmem_data_out;
         end
         if (rd1) begin
            rdata1_q <= bus.dmem_data_out;
         end
      end
   end

`ifdef DMEM_ARB_RR_EN
   // Reset to 1 so m0 wins the first contention.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   assign bus.m0_gnt        = gnt0;
   assign bus.m1_gnt        = gnt1;
   assign bus.m0_rvalid     = rvalid0_q;
   assign bus.m1_rvalid     = rvalid1_q;
   assign bus.m0_rdata      = rdata0_q;
   assign bus.m1_rdata      = rdata1_q;
   assign bus.dmem_addr     = addr_mux;
   assign bus.dmem_data_in  = wdata_mux;
   assign bus.dmem_wr_en    = wr_mux;
   assign bus.dmem_mem_read = rd_mux;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single-port data memory (`dmem`) between the RISC core data port (master 0) and a secondary requester such as a program/debug loader (master 1). It sits between both masters and `dmem` and drives `dmem`'s address, write-data, write-enable and read-enable ports. It grants at most one access per cycle and returns registered read data one cycle after grant. It supports locked back-to-back sequences for read-modify-write operations.

## Interface
- `ADDR_WIDTH`, 32: address width of masters and `dmem`.
- `WORD_WIDTH`, 32: data word width.

- `clk`  in  1  sole clock, rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  access request, held until granted.
- `m0_wr_en`, `m1_wr_en`  in  1  1 = write, 0 = read.
- `m0_lock`, `m1_lock`  in  1  keep ownership after this access.
- `m0_addr`, `m1_addr`  in  ADDR_WIDTH  word-aligned byte address.
- `m0_wdata`, `m1_wdata`  in  WORD_WIDTH  write data.
- `m0_gnt`, `m1_gnt`  out  1  access performed this cycle (combinational).
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid, registered, 1-cycle pulse.
- `m0_rdata`, `m1_rdata`  out  WORD_WIDTH  registered read data.
- `dmem_addr`  out  ADDR_WIDTH  to `dmem`.
- `dmem_data_in`  out  WORD_WIDTH  to `dmem`.
- `dmem_wr_en`  out  1  to `dmem`.
- `dmem_mem_read`  out  1  to `dmem`.
- `dmem_data_out`  in  WORD_WIDTH  combinational read data from `dmem`.

## Operation
- **Owner state register:** FREE, LOCK0, LOCK1.
  - Reset value: FREE.
- **Priority pointer `last`:** records the last granted master.
  - Reset value: 1, so m0 wins the first contention.
- **FREE:**
  - Only one master requesting: grant it.
  - Both requesting: grant `~last` (round-robin).
  - Neither requesting: no grant. `dmem_wr_en` and `dmem_mem_read` are 0, `dmem_addr` and `dmem_data_in` are 0.
- **LOCKn:**
  - Only master n may be granted. The other master's `req` is ignored; its `gnt` stays 0.
  - Master n with `req` = 0 in LOCKn: no access, and state returns to FREE at the next edge.
- **Transitions on a granted access by master n:**
  - `mn_lock` = 1: next state LOCKn.
  - `mn_lock` = 0: next state FREE.
- **Pointer:** `last` is updated to n on every grant, including locked grants.
- **Muxing:** the granted master's `addr`, `wdata` and `wr_en` drive `dmem`.
  - `dmem_mem_read` = `gnt` & ~`wr_en`.
  - `dmem_wr_en` = `gnt` & `wr_en`.
- **Read return:** on a granted read, `dmem_data_out` is captured at that clock edge into `mn_rdata`, and `mn_rvalid` pulses high for the following cycle.
  - `rdata` holds its value until the next read by the same master.
- **Writes:** no `rvalid`; the write completes at the grant edge.
- **Addresses:** passed unchanged.
  - Misaligned addresses (`addr[1:0]` ≠ 0) are still forwarded. The `dmem` behaviour applies; the arbiter does not flag them.
- **Combinational requirement:** `gnt` must not depend combinationally on `rvalid` or `rdata`.

## Timing
- **Reset values:**
  - `m0_gnt` = `m1_gnt` = 0.
  - `m0_rvalid` = `m1_rvalid` = 0.
  - `m0_rdata` = `m1_rdata` = 0.
  - All `dmem_*` outputs = 0.
  - State = FREE, `last` = 1.
- **Latency:**
  - Grant: 0 cycles, same cycle as `req` when uncontended.
  - Read data: 1 cycle after grant.
- **Throughput:** 1 access per cycle in total.
  - Alternating under continuous dual contention: m0, m1, m0, …
- **Simultaneous events:**
  - A master may issue a new request in the same cycle its previous `rvalid` is high.
  - A lock-release cycle (`lock` = 0 on a grant) and the other master's request: the other master is granted the next cycle, not the same cycle.
- **Reset mid-operation:** asserting `nrst` low immediately clears `rvalid`, `gnt` and the lock state. An in-flight read is discarded; no `rvalid` appears after reset.
- **Starvation bound:**
  - Unlocked: a requesting master is granted within 2 cycles.
  - Locked: no bound. The lock holder must release.

## Configuration
- Macro `DMEM_ARB_RR_EN`.
  - **Defined:** round-robin contention resolution as described, using `last`.
  - **Undefined:** fixed priority, m0 always wins contention in FREE. `last` is not implemented. Lock behaviour is unchanged.

## Test plan
- **Uncontended read:** preload `dmem[0x10]` = 0xDEADBEEF; m0 read at 0x10.
  - `m0_gnt` = 1 in the same cycle.
  - Next cycle: `m0_rvalid` = 1, `m0_rdata` = 0xDEADBEEF.
- **Dual contention (RR enabled):** both masters request continuously for 4 cycles.
  - Grants are m0, m1, m0, m1.
  - With the macro undefined: m0 is granted all 4 cycles.
- **Write-then-read:** m1 writes 0x12345678 to 0x20, then m0 reads 0x20.
  - `m0_rdata` = 0x12345678.
  - `m1_rvalid` never asserts.
- **Lock:** m1 issues a locked read of 0x30 then an unlocked write of 0x30 (value+1), while m0 requests throughout.
  - m0 is not granted during either access.
  - m0 is granted on the cycle after the unlock.
  - `dmem[0x30]` is incremented.
- **Reset mid-read:** m0 read granted, then pull `nrst` low before the next rising edge.
  - `m0_rvalid` stays 0 and `m0_rdata` is 0.
  - State is FREE after reset; m0 wins the first contention.
- **Idle:** no requests for 3 cycles.
  - `dmem_wr_en` = `dmem_mem_read` = 0.
  - `dmem_addr` = 0.
  - No `gnt` or `rvalid`.
